// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin merger of NCH channel output FIFOs into one 16-bit block stream.
// A grant drains one whole block (control word plus L data words) before the next channel
// is considered, so blocks never interleave on dout.
// Optional build macro: ARB_CWCHK_EN enables control-word checking, the DROP state and the
// sticky cw_err flag. Without it cw_err is tied low and every CW is trusted.
module chan_arbiter #(
  parameter int unsigned NCH = 16,
  parameter int unsigned CHW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    ack,
  input  logic [16*NCH-1:0] din,
  input  logic              ofull,
  output logic [15:0]       dout,
  output logic              dout_we,
  output logic              dout_sob,
  output logic              busy,
  output logic              cw_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAck  = 2'd1;
  localparam logic [1:0] StTail = 2'd2;
`ifdef ARB_CWCHK_EN
  localparam logic [1:0] StDrop = 2'd3;
`endif

  logic [1:0]     state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic [8:0]     len_q, len_d;
  logic [9:0]     cnt_q, cnt_d;
  logic           tail_q, tail_d;   // one extra TAIL cycle pending (after DROP)
  logic           drop_q, drop_d;   // current TAIL belongs to a dropped word: no output
  logic [15:0]    dout_q;
  logic           dout_we_q;
  logic           dout_sob_q;

  logic           gnt_found;
  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] sel_ch;
  logic [15:0]    sel_word;
  logic           ack_on;
  logic           wr_en;
  logic           sob_en;

`ifdef ARB_CWCHK_EN
  logic           err_q, err_d;
  logic           cw_bad;
`endif

  // Round-robin search: first requesting channel strictly after rr_q, wrapping to 0.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = (32'(rr_q) + i) % NCH;
      if (!gnt_found && req[idx[CHW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[CHW-1:0];
      end
    end
  end

  // In IDLE the candidate's CW is inspected; afterwards the granted channel is streamed.
  assign sel_ch   = (state_q == StIdle) ? gnt_idx : ch_q;
  assign sel_word = din[{sel_ch, 4'b0000} +: 16];

`ifdef ARB_CWCHK_EN
  assign cw_bad = !sel_word[15] || (sel_word[8:0] == 9'd0);
  assign ack_on = (state_q == StAck) || (state_q == StDrop);
`else
  assign ack_on = (state_q == StAck);
`endif

  // Word i of the block reaches din two cycles after its ack, so writes lag ack by one
  // cycle and the final word is written during TAIL.
  assign wr_en  = ((state_q == StAck) && (cnt_q != 10'd0)) ||
                  ((state_q == StTail) && !drop_q);
  assign sob_en = ((state_q == StAck) && (cnt_q == 10'd1)) ||
                  ((state_q == StTail) && !drop_q && (len_q == 9'd0));

  assign busy = (state_q != StIdle);

  // One-hot read strobe for the granted channel.
  always_comb begin
    ack = '0;
    if (ack_on) ack[ch_q] = 1'b1;
  end

  // Next-state logic for the IDLE -> ACK -> TAIL (-> IDLE) sequence.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    drop_d  = drop_q;
`ifdef ARB_CWCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (!ofull && gnt_found) begin
          ch_d   = gnt_idx;
          rr_d   = gnt_idx;
          len_d  = sel_word[8:0];
          cnt_d  = 10'd0;
          tail_d = 1'b0;
          drop_d = 1'b0;
`ifdef ARB_CWCHK_EN
          state_d = cw_bad ? StDrop : StAck;
`else
          state_d = StAck;
`endif
        end
      end
      StAck: begin
        if (cnt_q == {1'b0, len_q}) begin
          state_d = StTail;
          tail_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StTail: begin
        if (tail_q) tail_d = 1'b0;
        else        state_d = StIdle;
      end
`ifdef ARB_CWCHK_EN
      StDrop: begin
        // Discard a single word so a desynchronised channel is drained word by word.
        state_d = StTail;
        tail_d  = 1'b1;
        drop_d  = 1'b1;
        err_d   = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM and block bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      rr_q    <= CHW'(NCH - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      drop_q  <= drop_d;
    end
  end

  // Output pipeline: dout follows the selected channel's din by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q     <= '0;
      dout_we_q  <= 1'b0;
      dout_sob_q <= 1'b0;
    end else begin
      dout_we_q  <= wr_en;
      dout_sob_q <= sob_en;
      if (wr_en) dout_q <= sel_word;
    end
  end

  assign dout     = dout_q;
  assign dout_we  = dout_we_q;
  assign dout_sob = dout_sob_q;

`ifdef ARB_CWCHK_EN
  // Sticky bad-CW flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign cw_err = err_q;
`else
  assign cw_err = 1'b0;
`endif

endmodule

// File: tb/tb_chan_arbiter.sv
// tb_chan_arbiter: randomized and directed checks of chan_arbiter against a queue-level
// round-robin model of the channel FIFOs.
module tb_chan_arbiter;
  localparam int NCH   = 16;
  localparam int CHW   = 4;
  localparam int DEPTH = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    ack;
  logic [16*NCH-1:0] din;
  logic              ofull;
  logic [15:0]       dout;
  logic              dout_we;
  logic              dout_sob;
  logic              busy;
  logic              cw_err;

  chan_arbiter #(.NCH(NCH), .CHW(CHW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ack      (ack),
    .din      (din),
    .ofull    (ofull),
    .dout     (dout),
    .dout_we  (dout_we),
    .dout_sob (dout_sob),
    .busy     (busy),
    .cw_err   (cw_err)
  );

  always #4 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Channel FIFOs: din shows fifo[rdptr] registered, so a new word appears 2 clk after ack.
  logic [15:0]  fifo_mem [NCH][DEPTH];
  int unsigned  wptr [NCH];
  int unsigned  rdp  [NCH];
  logic [15:0]  din_r [NCH];
  logic [NCH-1:0] req_r;

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (reset) begin
        rdp[k]   <= 0;
        req_r[k] <= 1'b0;
      end else begin
        rdp[k]   <= rdp[k] + 32'(ack[k]);
        req_r[k] <= (rdp[k] != wptr[k]);
      end
      din_r[k] <= fifo_mem[k][rdp[k] % DEPTH];
    end
  end

  always_comb begin
    din = '0;
    for (int k = 0; k < NCH; k++) din[k*16 +: 16] = din_r[k];
  end
  assign req = req_r;

  // Reference model: per-channel word queues served block by block in round-robin order.
  logic [15:0] mq [NCH][$];
  int          m_rr;
  bit          m_err;
  int          exp_word[$];     // bit16 = sob, [15:0] = word
  int          exp_ack_ch[$];
  int          exp_ack_len[$];

  task automatic push_word(input int k, input logic [15:0] w);
    fifo_mem[k][wptr[k] % DEPTH] = w;
    wptr[k]++;
    mq[k].push_back(w);
  endtask

  task automatic push_block(input int k, input int len);
    push_word(k, 16'h8000 | 16'(k << 9) | 16'(len));
    for (int i = 0; i < len; i++) push_word(k, 16'($urandom));
  endtask

  task automatic build_expect();
    int k;
    int len;
    logic [15:0] cw;
    logic [15:0] w;
    bit bad;
    forever begin
      k = -1;
      for (int i = 1; i <= NCH; i++) begin
        if (k < 0 && mq[(m_rr + i) % NCH].size() > 0) k = (m_rr + i) % NCH;
      end
      if (k < 0) break;
      m_rr = k;
      cw   = mq[k][0];
      bad  = 1'b0;
`ifdef ARB_CWCHK_EN
      bad = !cw[15] || (cw[8:0] == 9'd0);
`endif
      if (bad) begin
        exp_ack_ch.push_back(k);
        exp_ack_len.push_back(1);
        w = mq[k].pop_front();
        m_err = 1'b1;
      end else begin
        len = int'(cw[8:0]);
        exp_ack_ch.push_back(k);
        exp_ack_len.push_back(len + 1);
        for (int i = 0; i <= len; i++) begin
          w = mq[k].pop_front();
          exp_word.push_back(((i == 0) ? 32'h10000 : 32'h0) | int'(w));
        end
      end
    end
  endtask

  // Monitor state.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en;
  bit gap_chk;
  int drain_id;
  int grants[$];
  int rises[$];
  int n_words;

  initial begin
    int run_len, run_ch, last_rise, prev_rise, prev_len, prev_drain, e;
    bit prev_valid;
    run_len = 0; run_ch = 0; last_rise = 0; prev_rise = 0; prev_len = 0; prev_drain = -1;
    prev_valid = 1'b0; n_words = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        run_len    = 0;
        prev_valid = 1'b0;
      end else begin
        if (ack != '0) begin
          check("ack_onehot", $countones(ack), 1);
          if (run_len == 0) begin
            for (int b = 0; b < NCH; b++) if (ack[b]) run_ch = b;
            last_rise = cyc;
            grants.push_back(run_ch);
            rises.push_back(cyc);
            if (gap_chk && prev_valid && prev_drain == drain_id)
              check("grant_gap", cyc - prev_rise, prev_len + 2);
            run_len = 1;
          end else begin
            check("ack_hold", ack[run_ch], 1);
            run_len++;
          end
        end else if (run_len > 0) begin
          if (exp_ack_ch.size() == 0) begin
            check("ack_extra", run_ch, -1);
          end else begin
            check("ack_ch", run_ch, exp_ack_ch.pop_front());
            check("ack_len", run_len, exp_ack_len.pop_front());
          end
          prev_rise  = last_rise;
          prev_len   = run_len;
          prev_valid = 1'b1;
          prev_drain = drain_id;
          run_len    = 0;
        end
        if (dout_we) begin
          n_words++;
          if (exp_word.size() == 0) begin
            check("dout_extra", dout, -1);
          end else begin
            e = exp_word.pop_front();
            check("dout", dout, e & 32'hffff);
            check("dout_sob", dout_sob, (e >> 16) & 1);
            if (dout_sob) check("sob_lat", cyc - last_rise, 2);
          end
        end else begin
          check("sob_without_we", dout_sob, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      wptr[k] = 0;
      mq[k].delete();
    end
    exp_word.delete();
    exp_ack_ch.delete();
    exp_ack_len.delete();
    m_rr  = NCH - 1;
    m_err = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input bit tog);
    int n;
    n = 0;
    while ((exp_word.size() != 0 || exp_ack_ch.size() != 0 || busy) && n < budget) begin
      if (tog) ofull = ($urandom_range(0, 2) == 0);
      tick();
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    ofull = 1'b1;
    repeat (3) tick();
  endtask

  task automatic release_and_drain(input bit tog, input int budget);
    build_expect();
    drain_id++;
    gap_chk = !tog;
    ofull   = 1'b0;
    wait_drain(budget, tog);
    check("cw_err", cw_err, m_err);
  endtask

  int exp_g2[3] = '{0, 5, 15};
  int exp_g3[4] = '{2, 7, 2, 2};
  int t_start;
  int w0;
  int n;

  initial begin
    #(8 * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ofull = 1'b1; reset = 1'b1; mon_en = 1'b0; gap_chk = 1'b0; drain_id = 0;
    m_rr = NCH - 1; m_err = 1'b0;
    for (int k = 0; k < NCH; k++) wptr[k] = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ack", ack, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_we", dout_we, 0);
    check("rst_dout_sob", dout_sob, 0);
    check("rst_busy", busy, 0);
    check("rst_cw_err", cw_err, 0);
    mon_en = 1'b1;

    // Channel 3 alone, CW 0x8605 then 1..5.
    grants.delete();
    push_word(3, 16'h8605);
    for (int i = 1; i <= 5; i++) push_word(3, 16'(i));
    w0 = n_words;
    release_and_drain(1'b0, 100);
    check("t1_grants", grants.size(), 1);
    if (grants.size() > 0) check("t1_grant_ch", grants[0], 3);
    check("t1_words", n_words - w0, 6);

    // Channels 0, 5, 15 simultaneously after reset.
    do_reset();
    grants.delete();
    push_block(0, 2); push_block(5, 2); push_block(15, 2);
    w0 = n_words;
    release_and_drain(1'b0, 100);
    check("t2_grants", grants.size(), 3);
    for (int i = 0; i < 3; i++) if (grants.size() > i) check("t2_order", grants[i], exp_g2[i]);
    check("t2_words", n_words - w0, 9);

    // Channel 2 with three blocks, channel 7 with one.
    grants.delete();
    push_block(2, 1); push_block(2, 1); push_block(2, 1); push_block(7, 1);
    release_and_drain(1'b0, 100);
    check("t3_grants", grants.size(), 4);
    for (int i = 0; i < 4; i++) if (grants.size() > i) check("t3_order", grants[i], exp_g3[i]);

    // ofull holds off a pending block; raising it mid-block does not stop the block.
    push_block(1, 4);
    repeat (6) begin
      tick();
      check("t4_ack_held", ack, 0);
      check("t4_busy_held", busy, 0);
    end
    build_expect();
    drain_id++;
    gap_chk = 1'b0;
    ofull   = 1'b0;
    t_start = cyc;
    tick(); tick();
    ofull = 1'b1;
    wait_drain(100, 1'b0);
    check("t4_start", rises[rises.size()-1], t_start + 1);

    // Maximum block length followed by a short block.
    rises.delete();
    push_block(9, 511); push_block(10, 1);
    w0 = n_words;
    release_and_drain(1'b0, 1500);
    check("t5_words", n_words - w0, 514);
    check("t5_rises", rises.size(), 2);
    if (rises.size() == 2) check("t5_next_ack", rises[1] - rises[0], 514);

`ifdef ARB_CWCHK_EN
    // Garbage word ahead of a valid CW is dropped and flagged.
    check("t6_err_before", cw_err, 0);
    grants.delete();
    push_word(4, 16'h1234); push_word(4, 16'h8801); push_word(4, 16'hAAAA);
    w0 = n_words;
    release_and_drain(1'b0, 100);
    check("t6_err_after", cw_err, 1);
    check("t6_acks", grants.size(), 2);
    check("t6_words", n_words - w0, 2);
`else
    // L=0 forwards the CW alone.
    w0 = n_words;
    push_block(11, 0); push_block(12, 3);
    release_and_drain(1'b0, 100);
    check("t6_words", n_words - w0, 5);
`endif

    // Randomized scenarios, alternating steady and toggling ofull.
    for (int it = 0; it < 8; it++) begin
      int nb;
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) push_block($urandom_range(0, NCH - 1), $urandom_range(1, 24));
      release_and_drain(it[0], 3000);
    end

    // Reset in the middle of a block.
    push_block(6, 10);
    build_expect();
    drain_id++;
    gap_chk = 1'b0;
    ofull   = 1'b0;
    n = 0;
    while (ack[6] == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("t7_block_started", n < 20, 1);
    repeat (3) tick();
    check("t7_busy_mid", busy, 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    check("t7_ack", ack, 0);
    check("t7_dout", dout, 0);
    check("t7_dout_we", dout_we, 0);
    check("t7_dout_sob", dout_sob, 0);
    check("t7_busy", busy, 0);
    check("t7_cw_err", cw_err, 0);
    ofull = 1'b1;
    do_reset();

    // Recovery after reset: rr pointer back at NCH-1, so channel 0 wins.
    grants.delete();
    push_block(3, 2); push_block(0, 3);
    release_and_drain(1'b0, 100);
    check("t8_grants", grants.size(), 2);
    if (grants.size() > 0) check("t8_first", grants[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
